// File: rtl/synth_pkg.sv
// Shared constants, FSM encoding and output saturation for the voice bank.
// Latency: n/a (package); backpressure: n/a.
package synth_pkg;

  localparam logic [2:0] SEL_SILENCE = 3'b000;
  localparam logic [2:0] SEL_SQUARE  = 3'b001;
  localparam logic [2:0] SEL_SAW     = 3'b010;
  localparam logic [2:0] SEL_TRI     = 3'b011;
  localparam logic [2:0] SEL_NOISE   = 3'b100;

  // Fibonacci taps b15, b13, b12, b10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_VOICE = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef struct packed {
    logic               clip;
    logic signed [63:0] val;
  } sat_t;

  function automatic sat_t saturate(input logic signed [63:0] acc, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (w - 1));
    r.clip = 1'b0;
    r.val  = acc;
    if (acc > hi) begin
      r.clip = 1'b1;
      r.val  = hi;
    end else if (acc < lo) begin
      r.clip = 1'b1;
      r.val  = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/synth_wavegen.sv
// Combinational waveform generator shared by all voices (square/saw/triangle/noise).
// Latency: 0 cycles; backpressure: none.
module synth_wavegen
  import synth_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] p,
  input  logic [2:0]        sel,
  input  logic [15:0]       lfsr,
  output logic [DATA_W-1:0] wave
);

  logic [DATA_W+15:0] noise_ext;
  logic [DATA_W-1:0]  tri_t;
  logic               unused_ok;

  assign noise_ext = {{DATA_W{1'b0}}, lfsr};
  assign tri_t     = {(p[DATA_W-1] ? ~p[DATA_W-2:0] : p[DATA_W-2:0]), 1'b0};
  assign unused_ok = ^noise_ext[DATA_W+15:DATA_W];

  always_comb begin
    wave = '0;
    case (sel)
      SEL_SQUARE: wave = p[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
      SEL_SAW:    wave = {~p[DATA_W-1], p[DATA_W-2:0]};
      SEL_TRI:    wave = {~tri_t[DATA_W-1], tri_t[DATA_W-2:0]};
      SEL_NOISE:  wave = noise_ext[DATA_W-1:0];
      default:    wave = '0;
    endcase
  end

endmodule

// File: rtl/synth_voice_bank.sv
// Multi-voice oscillator bank: one time-multiplexed voice per cycle, saturated mix per sample tick.
// Latency: o_valid NUM_VOICES+1 cycles after each tick; backpressure: none (config writes always accepted).
module synth_voice_bank
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int DATA_W     = 16,
  parameter int PHASE_W    = 24,
  parameter int CLK_DIV    = 1042,
  localparam int VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic               i_clk50mhz,
  input  logic               i_rst_n,
  input  logic               i_cfg_we,
  input  logic [VIDX_W-1:0]  i_cfg_voice,
  input  logic [PHASE_W-1:0] i_cfg_freq,
  input  logic [DATA_W-1:0]  i_cfg_amp,
  input  logic [2:0]         i_cfg_mux_sel,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic               o_clip
);

  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES) + 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  logic [PHASE_W-1:0] phase [NUM_VOICES];
  logic [PHASE_W-1:0] freq  [NUM_VOICES];
  logic [DATA_W-1:0]  amp   [NUM_VOICES];
  logic [2:0]         sel   [NUM_VOICES];

  logic [CNT_W-1:0]   div_cnt;
  logic               tick;
  logic [15:0]        lfsr;
  logic [1:0]         state;
  logic [VIDX_W-1:0]  vidx;
  logic signed [ACC_W-1:0] acc;

  logic [PHASE_W-1:0]        phase_nxt;
  logic [DATA_W-1:0]         p;
  logic [DATA_W-1:0]         wave;
  logic signed [2*DATA_W:0]  wave_ext;
  logic signed [2*DATA_W:0]  amp_ext;
  logic signed [2*DATA_W:0]  prod;
  logic signed [DATA_W:0]    term;
  logic signed [ACC_W-1:0]   acc_nxt;
  sat_t                      sat;
  logic                      unused_ok;

  assign tick      = (div_cnt == CNT_W'(CLK_DIV - 1));
  assign phase_nxt = phase[vidx] + freq[vidx];
  assign p         = phase_nxt[PHASE_W-1 -: DATA_W];

  synth_wavegen #(.DATA_W(DATA_W)) u_wavegen (
    .p    (p),
    .sel  (sel[vidx]),
    .lfsr (lfsr),
    .wave (wave)
  );

  // Signed wave times unsigned amp; dropping the low DATA_W bits floors the result.
  assign wave_ext  = {{(DATA_W+1){wave[DATA_W-1]}}, wave};
  assign amp_ext   = {{(DATA_W+1){1'b0}}, amp[vidx]};
  assign prod      = wave_ext * amp_ext;
  assign term      = prod[2*DATA_W:DATA_W];
  assign acc_nxt   = acc + ACC_W'(term);
  assign sat       = saturate(64'(acc_nxt), DATA_W);
  assign unused_ok = ^{prod[DATA_W-1:0], sat.val[63:DATA_W]};

  always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        freq[i] <= '0;
        amp[i]  <= '0;
        sel[i]  <= SEL_SILENCE;
      end
    end else if (i_cfg_we && (int'(i_cfg_voice) < NUM_VOICES)) begin
      freq[i_cfg_voice] <= i_cfg_freq;
      amp[i_cfg_voice]  <= i_cfg_amp;
      sel[i_cfg_voice]  <= i_cfg_mux_sel;
    end
  end

  always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
      div_cnt <= '0;
      lfsr    <= LFSR_SEED;
      state   <= ST_IDLE;
      vidx    <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_clip  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_VOICE;
            vidx  <= '0;
            acc   <= '0;
          end
        end
        ST_VOICE: begin
          phase[vidx] <= phase_nxt;
          acc         <= acc_nxt;
          // Outputs load on the edge entering OUT so the pulse lands NUM_VOICES+1 after the tick.
          if (int'(vidx) == NUM_VOICES - 1) begin
            state   <= ST_OUT;
            o_data  <= sat.val[DATA_W-1:0];
            o_clip  <= sat.clip;
            o_valid <= 1'b1;
          end else begin
            vidx <= vidx + 1'b1;
          end
        end
        ST_OUT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_voice_bank.sv
// Scoreboard bench for synth_voice_bank: directed voice configurations with hand-derived samples.
// Expected samples are queued by the stimulus; a monitor pops and compares on every o_valid.
module tb_synth_voice_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_voice = '0;
  logic [23:0] cfg_freq = '0;
  logic [15:0] cfg_amp = '0;
  logic [2:0]  cfg_sel = '0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_clip;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int data;
    bit clip;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  synth_voice_bank #(
    .NUM_VOICES(4), .DATA_W(16), .PHASE_W(24), .CLK_DIV(16)
  ) dut (
    .i_clk50mhz    (clk),
    .i_rst_n       (rst_n),
    .i_cfg_we      (cfg_we),
    .i_cfg_voice   (cfg_voice),
    .i_cfg_freq    (cfg_freq),
    .i_cfg_amp     (cfg_amp),
    .i_cfg_mux_sel (cfg_sel),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_clip        (o_clip)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; cycle k follows the k-th rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid cyc=%0d data=%0d clip=%0b, required no pulse",
                 cyc, $signed(o_data), o_clip);
      end else begin
        e = sb.pop_front();
        if ($signed(o_data) != e.data || o_clip != e.clip || (e.at >= 0 && cyc != e.at)) begin
          n_err++;
          $display("FAIL sample cyc=%0d data=%0d clip=%0b, required cyc=%0d data=%0d clip=%0b",
                   cyc, $signed(o_data), o_clip, e.at, e.data, e.clip);
        end
      end
    end
  end

  task automatic push_exp(input int d, input bit c, input int at);
    exp_t x;
    x.data = d;
    x.clip = c;
    x.at   = at;
    sb.push_back(x);
  endtask

  // Called at a falling edge; asserts reset, checks outputs clear immediately, then releases.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_data !== 16'h0 || o_valid !== 1'b0 || o_clip !== 1'b0) begin
      n_err++;
      $display("FAIL %s data=%h valid=%b clip=%b, required 0/0/0", name, o_data, o_valid, o_clip);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_cfg(input logic [1:0] v, input logic [23:0] f,
                           input logic [15:0] a, input logic [2:0] s);
    cfg_we    = 1'b1;
    cfg_voice = v;
    cfg_freq  = f;
    cfg_amp   = a;
    cfg_sel   = s;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    @(negedge clk);

    // Idle bank: silent samples, first at cycle 20, period 16.
    do_reset("reset_initial");
    push_exp(0, 1'b0, 20);
    push_exp(0, 1'b0, 36);
    push_exp(0, 1'b0, 52);
    drain("idle");

    // Single full-scale square on voice 0.
    do_reset("reset_square");
    write_cfg(2'd0, 24'h800000, 16'hFFFF, 3'b001);
    push_exp(-32768, 1'b0, 20);
    push_exp(32766, 1'b0, 36);
    push_exp(-32768, 1'b0, 52);
    push_exp(32766, 1'b0, 68);
    drain("square");

    // Half-amplitude saw on voice 1: wave steps 4096 per sample, halved by amp.
    do_reset("reset_saw");
    write_cfg(2'd1, 24'h100000, 16'h8000, 3'b010);
    for (int k = 1; k <= 18; k++) push_exp((k % 16) * 2048 - 16384, 1'b0, -1);
    drain("saw");

    // Four in-phase squares overflow the output range both ways.
    do_reset("reset_clip");
    for (int v = 0; v < 4; v++) write_cfg(2'(v), 24'h800000, 16'hFFFF, 3'b001);
    push_exp(-32768, 1'b1, 20);
    push_exp(32767, 1'b1, 36);
    push_exp(-32768, 1'b1, 52);
    push_exp(32767, 1'b1, 68);
    drain("clip");

    // Triangle on voice 3 at quarter-cycle steps.
    do_reset("reset_tri");
    write_cfg(2'd3, 24'h400000, 16'hFFFF, 3'b011);
    push_exp(0, 1'b0, -1);
    push_exp(32765, 1'b0, -1);
    push_exp(-2, 1'b0, -1);
    push_exp(-32768, 1'b0, -1);
    push_exp(0, 1'b0, -1);
    drain("tri");

    // Noise on voice 2 (LFSR 59C3, B387, 670F), then an unused select silences it.
    do_reset("reset_noise");
    write_cfg(2'd2, 24'h0, 16'hFFFF, 3'b100);
    push_exp(22978, 1'b0, 20);
    push_exp(-19577, 1'b0, 36);
    push_exp(26382, 1'b0, 52);
    drain("noise");
    write_cfg(2'd2, 24'h0, 16'hFFFF, 3'b101);
    push_exp(0, 1'b0, 68);
    push_exp(0, 1'b0, 84);
    drain("noise_off");

    // Write to voice 0 during its own evaluation cycle (32) only affects the following sample.
    do_reset("reset_midwrite");
    write_cfg(2'd0, 24'h800000, 16'hFFFF, 3'b001);
    push_exp(-32768, 1'b0, 20);
    push_exp(32766, 1'b0, 36);
    push_exp(-16384, 1'b0, 52);
    wait_cyc(32);
    write_cfg(2'd0, 24'h800000, 16'h8000, 3'b001);
    drain("midwrite");

    // Reset while voice 1 is being evaluated: outputs clear, aborted sample never appears.
    wait_cyc(65);
    do_reset("reset_midsample");
    push_exp(0, 1'b0, 20);
    push_exp(0, 1'b0, 36);
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
